// File: rtl/ialu_issue_ctrl.sv
// ialu_issue_ctrl: one-op-at-a-time sequencer between ID/EX and the integer ALU.
// Holds ALU inputs stable, waits for the result or divider done/timeout, emits one write-back record.
`default_nettype none

module ialu_issue_ctrl #(
    parameter int XLEN        = 32,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_ctrl,
    input  logic [2:0]      op_funct3,
    input  logic            op_funct7_5,
    input  logic            op_add,
    input  logic [XLEN-1:0] op_rs1,
    input  logic [XLEN-1:0] op_rs2,
    input  logic [4:0]      op_rd,
    output logic [2:0]      alu_ctrl,
    output logic [2:0]      alu_funct3,
    output logic            alu_funct7_5,
    output logic            alu_add_op,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_overflow,
    input  logic            alu_branch_taken,
    input  logic            alu_div_done,
    input  logic            alu_div_by_zero,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_branch_taken,
    output logic            wb_overflow,
    output logic            wb_div_zero,
    output logic            wb_timeout,
    output logic            wb_illegal,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_DIV_WAIT = 3'd2,
        S_CAPT     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [2:0]  C_CTRL_ADD  = 3'b000;
    localparam logic [2:0]  C_CTRL_DIV  = 3'b010;
    localparam logic [2:0]  C_CTRL_BR   = 3'b110;
    localparam logic [2:0]  C_CTRL_NONE = 3'b111;
    localparam logic [15:0] C_TO_LAST   = 16'(DIV_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            f7_q, f7_d;
    logic            add_q, add_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            br_q, br_d;
    logic            ovf_q, ovf_d;
    logic            dz_q, dz_d;
    logic            to_q, to_d;
    logic            ill_q, ill_d;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            funct3_q <= '0;
            f7_q     <= 1'b0;
            add_q    <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            br_q     <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            to_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            funct3_q <= funct3_d;
            f7_q     <= f7_d;
            add_q    <= add_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            br_q     <= br_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            to_q     <= to_d;
            ill_q    <= ill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        funct3_d = funct3_q;
        f7_d     = f7_q;
        add_d    = add_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        br_d     = br_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        to_d     = to_q;
        ill_d    = ill_q;

        // Flush beats everything, including a pending accept or write-back handshake.
        if (flush) begin
            state_d = S_IDLE;
            data_d  = '0;
            br_d    = 1'b0;
            ovf_d   = 1'b0;
            dz_d    = 1'b0;
            to_d    = 1'b0;
            ill_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        state_d  = S_ISSUE;
                        ctrl_d   = op_ctrl;
                        funct3_d = op_funct3;
                        f7_d     = op_funct7_5;
                        add_d    = op_add;
                        rs1_d    = op_rs1;
                        rs2_d    = op_rs2;
                        rd_d     = op_rd;
                    end
                end
                S_ISSUE: begin
                    if (ctrl_q == C_CTRL_BR) begin
                        br_d    = alu_branch_taken;
                        state_d = S_DONE;
                    end else if (ctrl_q == C_CTRL_NONE) begin
                        ill_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (ctrl_q == C_CTRL_DIV) begin
                        cnt_d   = '0;
                        state_d = S_DIV_WAIT;
                    end else begin
                        state_d = S_CAPT;
                    end
                end
                S_DIV_WAIT: begin
                    cnt_d = cnt_q + 16'd1;
                    if (alu_div_done) begin
                        dz_d    = alu_div_by_zero;
                        state_d = S_CAPT;
                    end else if (cnt_q == C_TO_LAST) begin
                        to_d    = 1'b1;
                        data_d  = '0;
                        state_d = S_DONE;
                    end
                end
                S_CAPT: begin
                    data_d  = alu_result;
                    ovf_d   = (ctrl_q == C_CTRL_ADD) & alu_overflow;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (wb_ready) begin
                        state_d = S_IDLE;
                        data_d  = '0;
                        br_d    = 1'b0;
                        ovf_d   = 1'b0;
                        dz_d    = 1'b0;
                        to_d    = 1'b0;
                        ill_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ctrl 111 outside the active states keeps every ALU unit (and the divider) idle.
    assign alu_ctrl        = ((state_q == S_ISSUE) || (state_q == S_DIV_WAIT) || (state_q == S_CAPT))
                             ? ctrl_q : C_CTRL_NONE;
    assign alu_funct3      = funct3_q;
    assign alu_funct7_5    = f7_q;
    assign alu_add_op      = add_q;
    assign alu_rs1         = rs1_q;
    assign alu_rs2         = rs2_q;
    assign op_ready        = (state_q == S_IDLE) & ~flush;
    assign busy            = (state_q != S_IDLE);
    assign wb_valid        = (state_q == S_DONE);
    assign wb_rd           = rd_q;
    assign wb_data         = data_q;
    assign wb_branch_taken = br_q;
    assign wb_overflow     = ovf_q;
    assign wb_div_zero     = dz_q;
    assign wb_timeout      = to_q;
    assign wb_illegal      = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_ialu_issue_ctrl.sv
// tb_ialu_issue_ctrl: scoreboard bench for ialu_issue_ctrl with a behavioural ALU/divider stub.
`default_nettype none

module tb_ialu_issue_ctrl;

    localparam int TO = 40;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        br;
        logic        ovf;
        logic        dz;
        logic        to;
        logic        ill;
    } rec_t;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_ctrl = 3'b000;
    logic [2:0]  op_funct3 = 3'b000;
    logic        op_funct7_5 = 1'b0;
    logic        op_add = 1'b0;
    logic [31:0] op_rs1 = '0;
    logic [31:0] op_rs2 = '0;
    logic [4:0]  op_rd = '0;
    logic [2:0]  alu_ctrl;
    logic [2:0]  alu_funct3;
    logic        alu_funct7_5;
    logic        alu_add_op;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_result = '0;
    logic        alu_overflow = 1'b0;
    logic        alu_branch_taken;
    logic        alu_div_done;
    logic        alu_div_by_zero;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_branch_taken;
    logic        wb_overflow;
    logic        wb_div_zero;
    logic        wb_timeout;
    logic        wb_illegal;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    rec_t sb[$];
    rec_t mon_e;
    int   div_cnt = 0;
    int   div_lat = 1000;

    always #5 CLK = ~CLK;

    ialu_issue_ctrl #(.XLEN(32), .DIV_TIMEOUT(TO)) dut (
        .CLK(CLK), .rst_n(rst_n), .flush(flush),
        .op_valid(op_valid), .op_ready(op_ready), .op_ctrl(op_ctrl), .op_funct3(op_funct3),
        .op_funct7_5(op_funct7_5), .op_add(op_add), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_rd(op_rd),
        .alu_ctrl(alu_ctrl), .alu_funct3(alu_funct3), .alu_funct7_5(alu_funct7_5),
        .alu_add_op(alu_add_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_branch_taken(alu_branch_taken),
        .alu_div_done(alu_div_done), .alu_div_by_zero(alu_div_by_zero),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_branch_taken(wb_branch_taken), .wb_overflow(wb_overflow), .wb_div_zero(wb_div_zero),
        .wb_timeout(wb_timeout), .wb_illegal(wb_illegal), .busy(busy)
    );

    // ALU stub: registered add (000) or xor (others), divider done after div_lat cycles of ctrl=010.
    logic [31:0] stub_sum;
    logic        stub_ovf;
    assign stub_sum         = alu_rs1 + alu_rs2;
    assign stub_ovf         = (alu_rs1[31] == alu_rs2[31]) && (stub_sum[31] != alu_rs1[31]);
    assign alu_branch_taken = (alu_ctrl == 3'b110) && (alu_funct3 == 3'b000) && (alu_rs1 == alu_rs2);
    assign alu_div_done     = (alu_ctrl == 3'b010) && (div_cnt == div_lat);
    assign alu_div_by_zero  = alu_div_done && (alu_rs2 == 32'd0);

    always @(posedge CLK) begin
        if (alu_ctrl == 3'b010) begin
            div_cnt <= div_cnt + 1;
            if (alu_div_done)
                alu_result <= (alu_rs2 == 32'd0) ? 32'hFFFF_FFFF : alu_rs1 / alu_rs2;
        end else begin
            div_cnt <= 0;
            if (alu_ctrl != 3'b111) begin
                alu_result   <= (alu_ctrl == 3'b000) ? stub_sum : (alu_rs1 ^ alu_rs2);
                alu_overflow <= stub_ovf;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every completed write-back handshake is matched against the scoreboard head.
    always @(negedge CLK) begin
        if (rst_n && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_record", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_data", wb_data, mon_e.data);
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
                chk("wb_branch_taken", {31'd0, wb_branch_taken}, {31'd0, mon_e.br});
                chk("wb_overflow", {31'd0, wb_overflow}, {31'd0, mon_e.ovf});
                chk("wb_div_zero", {31'd0, wb_div_zero}, {31'd0, mon_e.dz});
                chk("wb_timeout", {31'd0, wb_timeout}, {31'd0, mon_e.to});
                chk("wb_illegal", {31'd0, wb_illegal}, {31'd0, mon_e.ill});
            end
        end
    end

    // Present one op and return #1 after the accepting edge.
    task automatic accept_op(input logic [2:0] ctrl, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int g = 0;
        while (!op_ready && g < 100) begin
            @(posedge CLK); #1; g++;
        end
        chk("op_ready_before_accept", {31'd0, op_ready}, 32'd1);
        op_ctrl = ctrl; op_funct3 = f3; op_rs1 = a; op_rs2 = b; op_rd = rd;
        op_valid = 1'b1;
        @(posedge CLK); #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_wb(input logic [2:0] ctrl, output int lat);
        logic badctl = 1'b0;
        lat = 0;
        while (!wb_valid && lat < 200) begin
            if (alu_ctrl !== ctrl) badctl = 1'b1;
            @(posedge CLK); #1; lat++;
        end
        chk("alu_ctrl_held", {31'd0, badctl}, 32'd0);
        chk("wb_valid_seen", {31'd0, wb_valid}, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] ctrl, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input rec_t exp, input int exp_lat, input int hold);
        int lat;
        accept_op(ctrl, f3, a, b, rd);
        sb.push_back(exp);
        wait_wb(ctrl, lat);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("alu_ctrl_in_done", {29'd0, alu_ctrl}, 32'd7);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            chk("hold_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("hold_wb_data", wb_data, exp.data);
            chk("hold_op_ready", {31'd0, op_ready}, 32'd0);
        end
        wb_ready = 1'b1;
        @(posedge CLK); #1;
        wb_ready = 1'b0;
        chk("wb_valid_after_ack", {31'd0, wb_valid}, 32'd0);
    endtask

    function automatic rec_t mk(input logic [31:0] d, input logic [4:0] rd, input logic br,
                                input logic ovf, input logic dz, input logic to, input logic ill);
        rec_t r;
        r.data = d; r.rd = rd; r.br = br; r.ovf = ovf; r.dz = dz; r.to = to; r.ill = ill;
        return r;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_alu_ctrl"}, {29'd0, alu_ctrl}, 32'd7);
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge CLK);
        #1;
        chk_idle("reset");
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_alu_rs1", alu_rs1, 32'd0);
        chk("reset_op_ready", {31'd0, op_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge CLK); #1;

        run_op(3'b000, 3'b000, 32'd5, 32'd7, 5'd3, mk(32'd12, 5'd3, 0, 0, 0, 0, 0), 2, 0);
        run_op(3'b000, 3'b000, 32'h7FFF_FFFF, 32'd1, 5'd9, mk(32'h8000_0000, 5'd9, 0, 1, 0, 0, 0), 2, 5);
        run_op(3'b100, 3'b100, 32'h7FFF_FFFF, 32'd1, 5'd4, mk(32'h7FFF_FFFE, 5'd4, 0, 0, 0, 0, 0), 2, 0);

        div_lat = 33;
        run_op(3'b010, 3'b100, 32'd100, 32'd7, 5'd5, mk(32'd14, 5'd5, 0, 0, 0, 0, 0), 35, 0);
        run_op(3'b010, 3'b100, 32'd100, 32'd0, 5'd6, mk(32'hFFFF_FFFF, 5'd6, 0, 0, 1, 0, 0), 35, 0);
        div_lat = 1000;
        run_op(3'b010, 3'b100, 32'd100, 32'd7, 5'd8, mk(32'd0, 5'd8, 0, 0, 0, 1, 0), TO + 1, 0);
        div_lat = TO;
        run_op(3'b010, 3'b100, 32'd50, 32'd5, 5'd7, mk(32'd10, 5'd7, 0, 0, 0, 0, 0), TO + 2, 0);

        run_op(3'b110, 3'b000, 32'd3, 32'd3, 5'd10, mk(32'd0, 5'd10, 1, 0, 0, 0, 0), 1, 0);
        run_op(3'b110, 3'b000, 32'd3, 32'd4, 5'd11, mk(32'd0, 5'd11, 0, 0, 0, 0, 0), 1, 0);
        run_op(3'b111, 3'b000, 32'd1, 32'd2, 5'd12, mk(32'd0, 5'd12, 0, 0, 0, 0, 1), 1, 0);

        // Flush in the third DIV_WAIT cycle.
        div_lat = 1000;
        accept_op(3'b010, 3'b100, 32'd9, 32'd3, 5'd13);
        repeat (3) begin @(posedge CLK); #1; end
        chk("div_wait_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_op_ready", {31'd0, op_ready}, 32'd0);
        @(posedge CLK); #1;
        flush = 1'b0;
        #1;
        chk_idle("flush_div");
        chk("flush_div_op_ready", {31'd0, op_ready}, 32'd1);

        // Flush while the record waits in DONE.
        accept_op(3'b000, 3'b000, 32'd1, 32'd1, 5'd14);
        wait_wb(3'b000, lat);
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        #1;
        chk_idle("flush_done");
        chk("flush_done_op_ready", {31'd0, op_ready}, 32'd1);

        // Asynchronous reset mid DIV_WAIT.
        accept_op(3'b010, 3'b100, 32'd77, 32'd7, 5'd15);
        repeat (3) begin @(posedge CLK); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_alu_rs1", alu_rs1, 32'd0);
        chk("rst_mid_wb_rd", {27'd0, wb_rd}, 32'd0);
        @(posedge CLK); #1;
        rst_n = 1'b1;
        @(posedge CLK); #1;

        run_op(3'b000, 3'b000, 32'd1, 32'd2, 5'd16, mk(32'd3, 5'd16, 0, 0, 0, 0, 0), 2, 0);

        repeat (2) @(posedge CLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
